// File: rtl/ram_burst_loader.sv
// ram_burst_loader: copies an {addr,data} image from a synchronous ROM into RAM.
// Define RAM_BURST_LOADER_VERIFY_EN to add a readback pass that flags the first mismatching entry.
module ram_burst_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int N_ENTRIES = 32,
    parameter int IDX_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [IDX_W-1:0]         rom_idx,
    input  logic [ADDR_W+DATA_W-1:0] rom_entry,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [IDX_W-1:0]         err_idx
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ENTRIES - 1);

`ifdef RAM_BURST_LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, VFETCH, VWAIT, VREAD, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_re       = 1'b0;
    assign err          = 1'b0;
    assign err_idx      = '0;
`endif

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             last;

    // idx is the register presented to the ROM; it only moves on an accepted request
    assign rom_idx = idx;
    assign last    = idx == LAST;

    // Load sequencer: fetch, latch ROM word, hold write until accepted, then optionally read back
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef RAM_BURST_LOADER_VERIFY_EN
            mem_re    <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= FETCH;
                    idx   <= '0;
                    busy  <= 1'b1;
                    done  <= 1'b0;
`ifdef RAM_BURST_LOADER_VERIFY_EN
                    err     <= 1'b0;
                    err_idx <= '0;
`endif
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    mem_addr  <= rom_entry[ADDR_W+DATA_W-1:DATA_W];
                    mem_wdata <= rom_entry[DATA_W-1:0];
                    mem_we    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: if (mem_ready) begin
                    mem_we <= 1'b0;
                    if (last) begin
`ifdef RAM_BURST_LOADER_VERIFY_EN
                        idx   <= '0;
                        state <= VFETCH;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= FETCH;
                    end
                end
`ifdef RAM_BURST_LOADER_VERIFY_EN
                VFETCH: state <= VWAIT;
                VWAIT: begin
                    mem_addr  <= rom_entry[ADDR_W+DATA_W-1:DATA_W];
                    mem_wdata <= rom_entry[DATA_W-1:0];
                    mem_re    <= 1'b1;
                    state     <= VREAD;
                end
                VREAD: if (mem_ready) begin
                    mem_re <= 1'b0;
                    if (mem_rdata != mem_wdata && !err) begin
                        err     <= 1'b1;
                        err_idx <= idx;
                    end
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= VFETCH;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_loader.sv
// tb_ram_burst_loader: directed table and corner-case sequences for ram_burst_loader
module tb_ram_burst_loader;
`ifdef RAM_BURST_LOADER_VERIFY_EN
    localparam int   EXP_RUN  = 19;
    localparam logic EXP_ERR  = 1'b1;
    localparam int   EXP_EIDX = 2;
    localparam logic V_BUSY10 = 1'b1;
`else
    localparam int   EXP_RUN  = 10;
    localparam logic EXP_ERR  = 1'b0;
    localparam int   EXP_EIDX = 0;
    localparam logic V_BUSY10 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start_a, start_b, ready_a, corrupt;
    logic ready_b = 1'b1;
    logic [5:0]  rom_idx_a, eidx_a;
    logic [23:0] rom_entry_a;
    logic [15:0] addr_a;
    logic [7:0]  wdata_a, rdata_a;
    logic        we_a, re_a, busy_a, done_a, err_a;
    logic [0:0]  rom_idx_b, eidx_b;
    logic [27:0] rom_entry_b;
    logic [11:0] addr_b;
    logic [15:0] wdata_b, rdata_b;
    logic        we_b, re_b, busy_b, done_b, err_b;
    logic [23:0] rom_a [3] = '{24'hFFFC00, 24'hFFFD80, 24'h8000A9};
    logic [7:0]  ram [65536];
    logic [15:0] ram_b = 16'h0;
    logic        overlap = 1'b0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ram_burst_loader #(.N_ENTRIES(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rom_idx(rom_idx_a), .rom_entry(rom_entry_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_we(we_a), .mem_re(re_a),
        .mem_ready(ready_a), .mem_rdata(rdata_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_idx(eidx_a));

    ram_burst_loader #(.ADDR_W(12), .DATA_W(16), .N_ENTRIES(1), .IDX_W(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rom_idx(rom_idx_b), .rom_entry(rom_entry_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_we(we_b), .mem_re(re_b),
        .mem_ready(ready_b), .mem_rdata(rdata_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_idx(eidx_b));

    // synchronous ROMs and RAM models; RAM A can corrupt address 8000 on readback
    always @(posedge clk) rom_entry_a <= (rom_idx_a < 6'd3) ? rom_a[rom_idx_a[1:0]] : 24'h0;
    always @(posedge clk) rom_entry_b <= (rom_idx_b == 1'b0) ? 28'h123BEEF : 28'h0;
    always @(posedge clk) if (we_a && ready_a) ram[addr_a] <= wdata_a;
    always @(posedge clk) if (we_b && ready_b) ram_b <= wdata_b;
    assign rdata_a = (corrupt && addr_a == 16'h8000) ? 8'hAA : ram[addr_a];
    assign rdata_b = ram_b;

    always @(negedge clk) if ((we_a && re_a) || (we_b && re_b)) overlap <= 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic run_to_done(input int lim);
        int n = 0;
        while (!done_a && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done_a), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, 32'(we_a), 0);
        check({tag, "_re"}, 32'(re_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_err"}, 32'(err_a), 0);
        check({tag, "_err_idx"}, 32'(eidx_a), 0);
        check({tag, "_addr"}, 32'(addr_a), 0);
        check({tag, "_wdata"}, 32'(wdata_a), 0);
        check({tag, "_rom_idx"}, 32'(rom_idx_a), 0);
    endtask

    typedef struct {
        logic        start;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t tv [11];

    initial begin
        int cyc, hi1, stall, nacc, maxi;
        logic stable, found, idle_ok;
        logic [15:0] acc [4];
        logic [11:0] ab;
        logic [15:0] db;
        tv[0]  = '{1'b1, 1'b0, 16'h0,    8'h00, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 16'h0,    8'h00, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 16'h0,    8'h00, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 16'hFFFC, 8'h00, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 16'h0,    8'h00, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 16'h0,    8'h00, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 16'hFFFD, 8'h80, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 16'h0,    8'h00, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 16'h0,    8'h00, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 16'h8000, 8'hA9, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b0, 16'h0,    8'h00, V_BUSY10, !V_BUSY10};
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; corrupt = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        // basic three-entry load, one entry every 3 cycles
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check($sformatf("tv%0d_we", i), 32'(we_a), 32'(tv[i].we));
            check($sformatf("tv%0d_re", i), 32'(re_a), 0);
            check($sformatf("tv%0d_busy", i), 32'(busy_a), 32'(tv[i].busy));
            check($sformatf("tv%0d_done", i), 32'(done_a), 32'(tv[i].done));
            if (tv[i].we) begin
                check($sformatf("tv%0d_addr", i), 32'(addr_a), 32'(tv[i].addr));
                check($sformatf("tv%0d_wdata", i), 32'(wdata_a), 32'(tv[i].wdata));
            end
            start_a = tv[i].start;
        end
        run_to_done(60);
        check("basic_err", 32'(err_a), 0);
        // entry 1 stalled for 5 cycles
        hi1 = 0; stall = 0; stable = 1'b1; nacc = 0;
        start_a = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (done_a) break;
            ready_a = 1'b1;
            if (we_a && addr_a == 16'hFFFD) begin
                hi1++;
                if (wdata_a !== 8'h80) stable = 1'b0;
                if (stall < 5) begin
                    ready_a = 1'b0;
                    stall++;
                end
            end
            if (we_a && ready_a) begin
                if (nacc < 4) acc[nacc] = addr_a;
                nacc++;
            end
        end
        ready_a = 1'b1;
        check("stall_done", 32'(done_a), 1);
        check("stall_we_cycles", 32'(hi1), 6);
        check("stall_wdata_stable", 32'(stable), 1);
        check("stall_accepts", 32'(nacc), 3);
        check("stall_acc0", 32'(acc[0]), 32'h FFFC);
        check("stall_acc1", 32'(acc[1]), 32'h FFFD);
        check("stall_acc2", 32'(acc[2]), 32'h8000);
        // start while busy is ignored; corrupted readback flags entry 2 when verify is built in
        corrupt = 1'b1; start_a = 1'b1; cyc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) check("busy_at_restart", 32'(busy_a), 1);
            start_a = (cyc == 4);
            if (done_a) break;
        end
        start_a = 1'b0;
        check("busy_start_run_len", 32'(cyc), 32'(EXP_RUN));
        check("corrupt_done", 32'(done_a), 1);
        check("corrupt_err", 32'(err_a), 32'(EXP_ERR));
        check("corrupt_err_idx", 32'(eidx_a), 32'(EXP_EIDX));
        corrupt = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_err_clr", 32'(err_a), 0);
        check("restart_busy", 32'(busy_a), 1);
        check("restart_done", 32'(done_a), 0);
        run_to_done(60);
        check("restart_err_final", 32'(err_a), 0);
        // reset while entry 2 write is pending
        start_a = 1'b1; found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (we_a && addr_a == 16'h8000) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_found_entry2", 32'(found), 1);
        ready_a = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b0; ready_a = 1'b1; idle_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (we_a || re_a || busy_a || done_a) idle_ok = 1'b0;
        end
        check("rst_stays_idle", 32'(idle_ok), 1);
        start_a = 1'b1; found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (we_a) begin
                found = 1'b1;
                break;
            end
        end
        check("reload_found", 32'(found), 1);
        check("reload_addr", 32'(addr_a), 32'hFFFC);
        check("reload_wdata", 32'(wdata_a), 0);
        run_to_done(60);
        // single-entry configuration
        start_b = 1'b1; nacc = 0; maxi = 0; ab = '0; db = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (int'(rom_idx_b) > maxi) maxi = int'(rom_idx_b);
            if (we_b) begin
                nacc++;
                ab = addr_b;
                db = wdata_b;
            end
            if (done_b) break;
        end
        check("one_accepts", 32'(nacc), 1);
        check("one_addr", 32'(ab), 32'h123);
        check("one_wdata", 32'(db), 32'hBEEF);
        check("one_max_idx", 32'(maxi), 0);
        check("one_done", 32'(done_b), 1);
        check("one_err", 32'(err_b), 0);
        check("no_we_re_overlap", 32'(overlap), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
